// File: rtl/tdr_scan_master.sv
// TDR scan initiator: runs one capture/shift/update access into a TDR chain and returns the bits shifted out.
// Optional macro TDR_SCAN_MASTER_RUNTEST_EN adds a post-update idle (RUN) phase of run_cycles cycles.
module tdr_scan_master #(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = $clog2(MAX_LEN+1)
) (
  input  logic               tck,
  input  logic               rst,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  input  logic [MAX_LEN-1:0] wdata,
`ifdef TDR_SCAN_MASTER_RUNTEST_EN
  input  logic [15:0]        run_cycles,
`endif
  output logic               busy,
  output logic               done,
  output logic [MAX_LEN-1:0] rdata,
  output logic               select,
  output logic               capture_en,
  output logic               shift_en,
  output logic               update_en,
  output logic               si,
  input  logic               so
);
  typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_SHIFT, S_UPDATE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d, cnt_q, cnt_d;
  logic [MAX_LEN-1:0] wsh_q, wsh_d, rdata_q, rdata_d;
  logic busy_q, busy_d, done_q, done_d, select_q, select_d;
  logic cap_q, cap_d, shift_q, shift_d, upd_q, upd_d, si_q, si_d;
`ifdef TDR_SCAN_MASTER_RUNTEST_EN
  logic [15:0] run_q, run_d, rcnt_q, rcnt_d;
`endif

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    wsh_d   = wsh_q;
    rdata_d = rdata_q;
`ifdef TDR_SCAN_MASTER_RUNTEST_EN
    run_d   = run_q;
    rcnt_d  = rcnt_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          len_d   = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
          wsh_d   = wdata;
          rdata_d = '0;
          cnt_d   = '0;
`ifdef TDR_SCAN_MASTER_RUNTEST_EN
          run_d   = run_cycles;
`endif
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: state_d = (len_q != '0) ? S_SHIFT : S_UPDATE;
      S_SHIFT: begin
        // so is sampled on the same edge the target shifts, so it is bit cnt_q
        for (int i = 0; i < MAX_LEN; i++)
          if (cnt_q == LEN_W'(i)) rdata_d[i] = so;
        cnt_d   = cnt_q + LEN_W'(1);
        state_d = (cnt_q + LEN_W'(1) == len_q) ? S_UPDATE : S_SHIFT;
      end
`ifdef TDR_SCAN_MASTER_RUNTEST_EN
      S_UPDATE: begin
        if (run_q != 16'd0) begin
          state_d = S_RUN;
          rcnt_d  = run_q;
        end else begin
          state_d = S_DONE;
        end
      end
      S_RUN: begin
        rcnt_d  = rcnt_q - 16'd1;
        state_d = (rcnt_q == 16'd1) ? S_DONE : S_RUN;
      end
`else
      S_UPDATE: state_d = S_DONE;
`endif
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered yet aligned to it
    busy_d   = (state_d == S_CAPTURE) || (state_d == S_SHIFT) || (state_d == S_UPDATE) ||
               (state_d == S_RUN);
    select_d = (state_d == S_CAPTURE) || (state_d == S_SHIFT) || (state_d == S_UPDATE);
    cap_d    = (state_d == S_CAPTURE);
    shift_d  = (state_d == S_SHIFT);
    upd_d    = (state_d == S_UPDATE);
    done_d   = (state_d == S_DONE);
    si_d     = 1'b0;
    if (state_d == S_SHIFT) begin
      si_d  = wsh_q[0];
      wsh_d = wsh_q >> 1;
    end
  end

  always_ff @(posedge tck or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      wsh_q    <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      select_q <= 1'b0;
      cap_q    <= 1'b0;
      shift_q  <= 1'b0;
      upd_q    <= 1'b0;
      si_q     <= 1'b0;
`ifdef TDR_SCAN_MASTER_RUNTEST_EN
      run_q    <= '0;
      rcnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      wsh_q    <= wsh_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      select_q <= select_d;
      cap_q    <= cap_d;
      shift_q  <= shift_d;
      upd_q    <= upd_d;
      si_q     <= si_d;
`ifdef TDR_SCAN_MASTER_RUNTEST_EN
      run_q    <= run_d;
      rcnt_q   <= rcnt_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rdata      = rdata_q;
  assign select     = select_q;
  assign capture_en = cap_q;
  assign shift_en   = shift_q;
  assign update_en  = upd_q;
  assign si         = si_q;
endmodule
